// File: rtl/stepper_pulse_gen.sv
// Multi-axis STEP/DIR pulse generator driven by a valid/ready move-command bus.
// Build option SYNC_GO_EN: accepted moves wait ARMED until a shared go strobe.
module stepper_pulse_gen #(
  parameter  int NUM_CH  = 2,
  parameter  int CNT_W   = 32,
  parameter  int PULSE_W = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_steps,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              cmd_dir,
  input  logic              abort,
  input  logic              go,
  output logic [NUM_CH-1:0] step_out,
  output logic [NUM_CH-1:0] dir_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done_pulse
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
`ifdef SYNC_GO_EN
    ARMED,
`endif
    DONE
  } state_e;

`ifdef SYNC_GO_EN
  localparam state_e START_ST = ARMED;
`else
  localparam state_e START_ST = SETUP;
  logic unused_go;
  assign unused_go = go;
`endif

  localparam logic [CNT_W-1:0] PW       = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] PW_M1    = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] PW_P1    = CNT_W'(PULSE_W + 1);
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [CNT_W-1:0]   rem_q   [NUM_CH];
  logic [CNT_W-1:0]   rem_d   [NUM_CH];
  logic [CNT_W-1:0]   per_q   [NUM_CH];
  logic [CNT_W-1:0]   per_d   [NUM_CH];
  logic [CNT_W-1:0]   tmr_q   [NUM_CH];
  logic [CNT_W-1:0]   tmr_d   [NUM_CH];
  logic [NUM_CH-1:0]  step_q, step_d;
  logic [NUM_CH-1:0]  dir_q, dir_d;
  logic [NUM_CH-1:0]  busy_q, busy_d;
  logic [NUM_CH-1:0]  done_q, done_d;
  logic [NUM_CH-1:0]  hit;
  logic               ch_busy;
  logic               accept;
  logic [CNT_W-1:0]   eff_period;

  always_comb begin
    ch_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cmd_ch == CH_W'(c)) ch_busy = busy_q[c];
    end
    cmd_ready  = !ch_busy && !abort && ({1'b0, cmd_ch} < NUM_CH_V);
    accept     = cmd_valid && cmd_ready;
    eff_period = (cmd_period > PW) ? cmd_period : PW_P1;
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c] = accept && (cmd_ch == CH_W'(c));
    end
  end

  // Pin outputs follow the state one cycle later, so DIR leads STEP by two edges.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      rem_d[c]   = rem_q[c];
      per_d[c]   = per_q[c];
      tmr_d[c]   = tmr_q[c];
      case (state_q[c])
        IDLE: begin
          if (hit[c]) begin
            state_d[c] = START_ST;
            rem_d[c]   = cmd_steps;
            per_d[c]   = eff_period;
          end
        end
`ifdef SYNC_GO_EN
        ARMED: begin
          if (go) state_d[c] = SETUP;
        end
`endif
        SETUP: begin
          if (rem_q[c] == '0) begin
            state_d[c] = DONE;
          end else begin
            state_d[c] = HIGH;
            rem_d[c]   = rem_q[c] - 1'b1;
            tmr_d[c]   = PW_M1;
          end
        end
        HIGH: begin
          if (tmr_q[c] == '0) begin
            state_d[c] = LOW;
            tmr_d[c]   = per_q[c] - PW_P1;
          end else begin
            tmr_d[c] = tmr_q[c] - 1'b1;
          end
        end
        LOW: begin
          if (tmr_q[c] != '0) begin
            tmr_d[c] = tmr_q[c] - 1'b1;
          end else if (rem_q[c] != '0) begin
            state_d[c] = HIGH;
            rem_d[c]   = rem_q[c] - 1'b1;
            tmr_d[c]   = PW_M1;
          end else begin
            state_d[c] = DONE;
          end
        end
        DONE:    state_d[c] = IDLE;
        default: state_d[c] = IDLE;
      endcase
      if (abort) state_d[c] = IDLE;
      step_d[c] = !abort && (state_q[c] == HIGH);
      done_d[c] = !abort && (state_q[c] == DONE);
      busy_d[c] = !abort && (hit[c] || (state_q[c] != IDLE));
      dir_d[c]  = hit[c] ? cmd_dir : dir_q[c];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        rem_q[c]   <= '0;
        per_q[c]   <= '0;
        tmr_q[c]   <= '0;
      end
      step_q <= '0;
      dir_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        rem_q[c]   <= rem_d[c];
        per_q[c]   <= per_d[c];
        tmr_q[c]   <= tmr_d[c];
      end
      step_q <= step_d;
      dir_q  <= dir_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: directed timing cases plus randomized traffic
// against a schedule-based model (pulse k rises at start+2+k*eff_period).
module tb_stepper_pulse_gen;
  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int PULSE_W = 4;
  localparam int CH_W    = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [CH_W-1:0]   cmd_ch = '0;
  logic [CNT_W-1:0]  cmd_steps = '0;
  logic [CNT_W-1:0]  cmd_period = '0;
  logic              cmd_dir = 1'b0;
  logic              abort = 1'b0;
  logic              go = 1'b0;
  logic [NUM_CH-1:0] step_out, dir_out, busy, done_pulse;

  stepper_pulse_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_steps(cmd_steps), .cmd_period(cmd_period), .cmd_dir(cmd_dir),
    .abort(abort), .go(go), .step_out(step_out), .dir_out(dir_out), .busy(busy),
    .done_pulse(done_pulse)
  );

  always #5 clock = ~clock;

  int     n_checks;
  int     n_pass;
  longint cyc;

  // Model: one move per channel described by its start edge and schedule.
  bit     m_act     [NUM_CH];
  bit     m_started [NUM_CH];
  longint m_start   [NUM_CH];
  longint m_steps   [NUM_CH];
  longint m_eff     [NUM_CH];
  bit     m_dir     [NUM_CH];

  longint rise_cyc [NUM_CH][8];
  int     rise_cnt [NUM_CH];
  longint done_cyc [NUM_CH];
  longint fall_cyc [NUM_CH];
  bit     prev_step[NUM_CH];
  bit     prev_busy[NUM_CH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c] = 0; m_started[c] = 0; m_start[c] = 0;
      m_steps[c] = 0; m_eff[c] = 1; m_dir[c] = 0;
    end
  endtask

  task automatic clear_log();
    for (int c = 0; c < NUM_CH; c++) begin
      rise_cnt[c] = 0; done_cyc[c] = -1; fall_cyc[c] = -1;
      prev_step[c] = 0; prev_busy[c] = 0;
      for (int k = 0; k < 8; k++) rise_cyc[c][k] = -1;
    end
  endtask

  function automatic bit model_ready();
    if (abort) return 0;
    if (int'(cmd_ch) >= NUM_CH) return 0;
    return !m_act[cmd_ch];
  endfunction

  task automatic tick();
    bit acc;
    logic [NUM_CH-1:0] es, eb, ed, edir;
    #1;
    acc = cmd_valid && model_ready();
    chk("cmd_ready", 64'(cmd_ready), 64'(model_ready()));
    @(posedge clock);
    cyc++;
    if (abort) begin
      for (int c = 0; c < NUM_CH; c++) m_act[c] = 0;
    end else begin
`ifdef SYNC_GO_EN
      if (go) begin
        for (int c = 0; c < NUM_CH; c++)
          if (m_act[c] && !m_started[c]) begin m_started[c] = 1; m_start[c] = cyc; end
      end
`endif
      if (acc) begin
        m_act[cmd_ch]   = 1;
        m_steps[cmd_ch] = longint'(cmd_steps);
        m_eff[cmd_ch]   = (cmd_period > PULSE_W) ? longint'(cmd_period) : PULSE_W + 1;
        m_dir[cmd_ch]   = cmd_dir;
`ifdef SYNC_GO_EN
        m_started[cmd_ch] = 0;
`else
        m_started[cmd_ch] = 1;
        m_start[cmd_ch]   = cyc;
`endif
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      longint rel, span;
      es[c] = 0; ed[c] = 0;
      span = m_steps[c] * m_eff[c];
      rel  = cyc - m_start[c] - 2;
      if (m_act[c] && m_started[c] && rel > span) m_act[c] = 0;
      eb[c]   = m_act[c];
      edir[c] = m_dir[c];
      if (m_act[c] && m_started[c] && rel >= 0) begin
        es[c] = (rel < span) && ((rel % m_eff[c]) < PULSE_W);
        ed[c] = (rel == span);
      end
    end
    #1;
    chk("step_out", 64'(step_out), 64'(es));
    chk("busy", 64'(busy), 64'(eb));
    chk("done_pulse", 64'(done_pulse), 64'(ed));
    chk("dir_out", 64'(dir_out), 64'(edir));
    for (int c = 0; c < NUM_CH; c++) begin
      if (step_out[c] && !prev_step[c]) begin
        if (rise_cnt[c] < 8) rise_cyc[c][rise_cnt[c]] = cyc;
        rise_cnt[c]++;
      end
      if (done_pulse[c]) done_cyc[c] = cyc;
      if (prev_busy[c] && !busy[c]) fall_cyc[c] = cyc;
      prev_step[c] = step_out[c];
      prev_busy[c] = busy[c];
    end
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input int ch, input int steps, input int per, input bit d);
    cmd_valid = 1; cmd_ch = CH_W'(ch); cmd_steps = CNT_W'(steps);
    cmd_period = CNT_W'(per); cmd_dir = d;
    #1;
    chk("issue_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 0;
  endtask

  initial begin
    longint e;
    n_checks = 0; n_pass = 0; cyc = 0;
    model_clear(); clear_log();
    repeat (2) @(negedge clock);
    chk("rst_step", 64'(step_out), 64'(0));
    chk("rst_dir", 64'(dir_out), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done_pulse), 64'(0));
    reset = 1;

    // Three pulses, period 10
    issue(0, 3, 10, 1); e = cyc;
    chk("t1_dir_at_E", 64'(dir_out[0]), 64'(1));
    chk("t1_busy_at_E", 64'(busy[0]), 64'(1));
    run(40);
    chk("t1_rise0", 64'(rise_cyc[0][0] - e), 64'(2));
    chk("t1_rise1", 64'(rise_cyc[0][1] - e), 64'(12));
    chk("t1_rise2", 64'(rise_cyc[0][2] - e), 64'(22));
    chk("t1_rises", 64'(rise_cnt[0]), 64'(3));
    chk("t1_done", 64'(done_cyc[0] - e), 64'(32));
    chk("t1_busy_fall", 64'(fall_cyc[0] - e), 64'(33));

    // Zero-step move
    clear_log();
    issue(1, 0, 5, 0); e = cyc;
    run(3);
    chk("t2_rises", 64'(rise_cnt[1]), 64'(0));
    chk("t2_done", 64'(done_cyc[1] - e), 64'(2));
    chk("t2_busy_fall", 64'(fall_cyc[1] - e), 64'(3));
    cmd_ch = 2'd1; #1;
    chk("t2_ready_E3", 64'(cmd_ready), 64'(1));

    // Period 1 clamps to PULSE_W+1
    clear_log();
    issue(0, 2, 1, 0); e = cyc;
    run(20);
    chk("t3_rises", 64'(rise_cnt[0]), 64'(2));
    chk("t3_rise0", 64'(rise_cyc[0][0] - e), 64'(2));
    chk("t3_rise1", 64'(rise_cyc[0][1] - e), 64'(7));
    chk("t3_done", 64'(done_cyc[0] - e), 64'(12));

    // Abort during the third pulse
    clear_log();
    issue(0, 100, 10, 1);
    for (int i = 0; i < 200 && rise_cnt[0] < 3; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t4_step_after_abort", 64'(step_out[0]), 64'(0));
    chk("t4_busy_after_abort", 64'(busy[0]), 64'(0));
    chk("t4_dir_kept", 64'(dir_out[0]), 64'(1));
    run(30);
    chk("t4_rises", 64'(rise_cnt[0]), 64'(3));
    chk("t4_no_done", 64'(done_cyc[0]), 64'(-1));

    // Asynchronous reset mid-move
    issue(0, 50, 6, 1);
    run(10);
    #2 reset = 0;
    #1;
    chk("t5_step", 64'(step_out), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done_pulse), 64'(0));
    chk("t5_dir", 64'(dir_out), 64'(0));
    model_clear(); clear_log();
    @(negedge clock);
    reset = 1;
    cmd_valid = 1; cmd_ch = '0; #1;
    chk("t5_ready_after_rst", 64'(cmd_ready), 64'(1));
    cmd_valid = 0;

`ifdef SYNC_GO_EN
    clear_log();
    issue(0, 2, 8, 0);
    issue(1, 1, 6, 1);
    run(20);
    chk("t6_no_step_armed", 64'(rise_cnt[0] + rise_cnt[1]), 64'(0));
    go = 1;
    tick(); e = cyc;
    go = 0;
    run(20);
    chk("t6_ch0_rise", 64'(rise_cyc[0][0] - e), 64'(2));
    chk("t6_ch1_rise", 64'(rise_cyc[1][0] - e), 64'(2));
`endif

    for (int i = 0; i < 3000; i++) begin
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_ch     = CH_W'($urandom_range(0, 3));
      cmd_steps  = CNT_W'($urandom_range(0, 4));
      cmd_period = CNT_W'($urandom_range(0, 12));
      cmd_dir    = 1'($urandom_range(0, 1));
      abort      = ($urandom_range(0, 63) == 0);
      go         = ($urandom_range(0, 15) == 0);
      tick();
    end
    cmd_valid = 0; abort = 0; go = 0;
    run(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
